// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and constants for the multi-word add sequencer.
package multiword_add_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } seq_state_t;

    // Pipeline depth of the registered adder: input regs, then output regs.
    localparam int ADD_LATENCY = 2;

    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer.sv
// Feeds wide operands through a narrow registered adder one word at a time,
// chaining the carry and assembling the full-width sum.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            Clk_CI,
    input  logic                            Rst_RI,
    input  logic                            InValid_SI,
    output logic                            InReady_SO,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] OpA_DI,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] OpB_DI,
    input  logic                            Cin_DI,
    output logic [DATA_WIDTH-1:0]           AddA_DO,
    output logic [DATA_WIDTH-1:0]           AddB_DO,
    output logic                            AddCin_DO,
    output logic                            AddWrEn_SO,
    input  logic [DATA_WIDTH-1:0]           AddSum_DI,
    input  logic                            AddCout_DI,
    output logic                            OutValid_SO,
    input  logic                            OutReady_SI,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] Result_DO,
    output logic                            Cout_DO
);

    localparam int OP_W  = NUM_WORDS * DATA_WIDTH;
    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [1:0] WAIT_CYCLES_M1 = 2'(ADD_LATENCY - 2);

    seq_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [1:0]       wait_cnt;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;

    // Word select stays combinational off registered state, so it is stable
    // for the whole ISSUE/WAIT/CAPTURE window of each word.
    assign AddA_DO   = op_a[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign AddB_DO   = op_b[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign AddCin_DO = carry;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            wait_cnt    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            Result_DO   <= '0;
            Cout_DO     <= 1'b0;
            OutValid_SO <= 1'b0;
            AddWrEn_SO  <= 1'b0;
            InReady_SO  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid_SI && InReady_SO) begin
                        op_a       <= OpA_DI;
                        op_b       <= OpB_DI;
                        carry      <= Cin_DI;
                        idx        <= '0;
                        InReady_SO <= 1'b0;
                        AddWrEn_SO <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_CYCLES_M1;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        AddWrEn_SO <= 1'b0;
                        state      <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                CAPTURE: begin
                    Result_DO[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= AddSum_DI;
                    carry <= AddCout_DI;
                    if (idx == LAST_IDX) begin
                        Cout_DO     <= AddCout_DI;
                        OutValid_SO <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx        <= idx + 1'b1;
                        AddWrEn_SO <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                DONE: begin
                    if (OutReady_SI) begin
                        OutValid_SO <= 1'b0;
                        InReady_SO  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
